// File: rtl/regfile_sb.sv
// Parametrised register file with N read ports, one write port,
// optional write-through bypass, hardwired zero register and pending-write scoreboard.
module regfile_sb #(
  parameter int WORD     = 32,
  parameter int SIZE     = 16,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = (SIZE > 2) ? $clog2(SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WORD-1:0]       wr_data,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*WORD-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  output logic                  rsv_ok,
  output logic [SIZE-1:0]       pending
);

  logic [WORD-1:0] regs [SIZE];
  logic [SIZE-1:0] pend;
  logic            wr_ok;

  function automatic logic valid(input logic [AW-1:0] a);
    return (int'(a) < SIZE) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok   = wr_en & valid(wr_addr);
  assign rsv_ok  = ~rst & rsv_en & valid(rsv_addr) & ~pend[rsv_addr];
  assign pending = pend;

  // A write clears the bit first so a same-cycle accepted reservation wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < SIZE; r++) regs[r] <= '0;
      pend <= '0;
    end else begin
      if (wr_ok) begin
        regs[wr_addr] <= wr_data;
        pend[wr_addr] <= 1'b0;
      end
      if (rsv_ok) pend[rsv_addr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;

    assign a   = rd_addr[i*AW +: AW];
    assign hit = (BYPASS != 0) && wr_en && (wr_addr == a);

    always_comb begin
      rd_data[i*WORD +: WORD] = '0;
      rd_busy[i]              = 1'b0;
      if (!rst && valid(a)) begin
        if (hit) begin
          rd_data[i*WORD +: WORD] = wr_data;
        end else begin
          rd_data[i*WORD +: WORD] = regs[a];
          rd_busy[i]              = pend[a];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: two configurations share stimulus and are
// checked against an array-based model of the register/scoreboard rules.
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [11:0] rd_addr;
  logic        rsv_en;
  logic [3:0]  rsv_addr;

  logic [95:0] rd_data_a, rd_data_b;
  logic [2:0]  rd_busy_a, rd_busy_b;
  logic        rsv_ok_a, rsv_ok_b;
  logic [15:0] pending_a;
  logic [11:0] pending_b;

  int checks = 0;
  int errors = 0;

  // a: 16 regs, bypass, zero reg; b: 12 regs, no bypass, no zero reg
  regfile_sb #(.WORD(32), .SIZE(16), .NREAD(3), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_a), .pending(pending_a));

  regfile_sb #(.WORD(32), .SIZE(12), .NREAD(3), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_b), .pending(pending_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int msize [2] = '{16, 12};
  bit mzero [2] = '{1'b1, 1'b0};
  bit mbyp  [2] = '{1'b1, 1'b0};
  logic [31:0] mreg  [2][16];
  bit          mpend [2][16];

  function automatic bit mvalid(int k, int a);
    return (a < msize[k]) && !(mzero[k] && a == 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++)
        for (int r = 0; r < 16; r++) begin
          mreg[k][r]  <= '0;
          mpend[k][r] <= 1'b0;
        end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wr_en && mvalid(k, int'(wr_addr))) begin
          mreg[k][wr_addr]  <= wr_data;
          mpend[k][wr_addr] <= 1'b0;
        end
        if (rsv_en && mvalid(k, int'(rsv_addr)) && !mpend[k][rsv_addr])
          mpend[k][rsv_addr] <= 1'b1;
      end
    end
  end

  function automatic logic [31:0] act_rd(int k, int i);
    return (k == 0) ? rd_data_a[i*32 +: 32] : rd_data_b[i*32 +: 32];
  endfunction

  function automatic logic act_busy(int k, int i);
    return (k == 0) ? rd_busy_a[i] : rd_busy_b[i];
  endfunction

  function automatic logic [15:0] act_pend(int k);
    return (k == 0) ? pending_a : {4'b0, pending_b};
  endfunction

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0;
    rsv_en = 0; rsv_addr = 0; rd_addr = 0;
  endtask

  task automatic randomize_inputs();
    wr_en    = 1'($urandom_range(0, 1));
    wr_addr  = 4'($urandom_range(0, 15));
    wr_data  = $urandom;
    rsv_en   = 1'($urandom_range(0, 1));
    rsv_addr = 4'($urandom_range(0, 15));
    rd_addr  = 12'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      randomize_inputs();
      #1;
      checks++;
      if (rd_data_a !== '0 || rd_data_b !== '0) begin
        errors++;
        $display("FAIL reset_rd_data a=%h b=%h want 0", rd_data_a, rd_data_b);
      end
      checks++;
      if (rd_busy_a !== '0 || rd_busy_b !== '0 || rsv_ok_a !== 0 || rsv_ok_b !== 0) begin
        errors++;
        $display("FAIL reset_busy_rsv busy=%b/%b rsv_ok=%b/%b want 0", rd_busy_a, rd_busy_b, rsv_ok_a, rsv_ok_b);
      end
      checks++;
      if (pending_a !== '0 || pending_b !== '0) begin
        errors++;
        $display("FAIL reset_pending a=%h b=%h want 0", pending_a, pending_b);
      end
    end
    @(negedge clk);
    idle();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    @(negedge clk);
    idle();
    rd_addr = {4'd5, 4'd5, 4'd5};
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_rd(0, i) !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL basic_r5_port%0d got %h want deadbeef", i, act_rd(0, i));
      end
    end
    rd_addr = {4'd5, 4'd5, 4'd6};
    #1;
    checks++;
    if (act_rd(0, 0) !== 32'h0) begin
      errors++;
      $display("FAIL basic_r6 got %h want 0", act_rd(0, 0));
    end
    @(negedge clk);
  endtask

  task automatic test_bypass();
    wr_en = 1; wr_addr = 7; wr_data = 32'h1234; rd_addr = 12'd7;
    #1;
    checks++;
    if (act_rd(0, 0) !== 32'h1234) begin
      errors++;
      $display("FAIL bypass_same_cycle got %h want 1234", act_rd(0, 0));
    end
    checks++;
    if (act_rd(1, 0) !== 32'h0) begin
      errors++;
      $display("FAIL nobypass_old got %h want 0", act_rd(1, 0));
    end
    @(negedge clk);
    idle();
    rd_addr = 12'd7;
    #1;
    checks++;
    if (act_rd(1, 0) !== 32'h1234) begin
      errors++;
      $display("FAIL nobypass_next got %h want 1234", act_rd(1, 0));
    end
    @(negedge clk);
  endtask

  task automatic test_zero();
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFF;
    @(negedge clk);
    idle();
    rsv_en = 1; rsv_addr = 0;
    #1;
    checks++;
    if (act_rd(0, 0) !== 32'h0) begin
      errors++;
      $display("FAIL zero_read got %h want 0", act_rd(0, 0));
    end
    checks++;
    if (rsv_ok_a !== 1'b0) begin
      errors++;
      $display("FAIL zero_rsv_ok got %b want 0", rsv_ok_a);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (pending_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL zero_pending got %b want 0", pending_a[0]);
    end
  endtask

  task automatic test_scoreboard();
    rsv_en = 1; rsv_addr = 3;
    #1;
    checks++;
    if (rsv_ok_a !== 1'b1) begin
      errors++;
      $display("FAIL sb_rsv_ok got %b want 1", rsv_ok_a);
    end
    @(negedge clk);
    idle();
    rd_addr = 12'd3;
    #1;
    checks++;
    if (pending_a[3] !== 1'b1 || act_busy(0, 0) !== 1'b1) begin
      errors++;
      $display("FAIL sb_pending got %b busy %b want 1 1", pending_a[3], act_busy(0, 0));
    end
    rsv_en = 1; rsv_addr = 3;
    #1;
    checks++;
    if (rsv_ok_a !== 1'b0) begin
      errors++;
      $display("FAIL sb_rersv got %b want 0", rsv_ok_a);
    end
    rsv_en = 0;
    wr_en = 1; wr_addr = 3; wr_data = 32'hAA;
    #1;
    checks++;
    if (act_busy(0, 0) !== 1'b0 || act_busy(1, 0) !== 1'b1) begin
      errors++;
      $display("FAIL sb_busy_write_cycle got a=%b b=%b want 0 1", act_busy(0, 0), act_busy(1, 0));
    end
    @(negedge clk);
    idle();
    rd_addr = 12'd3;
    #1;
    checks++;
    if (pending_a[3] !== 1'b0 || act_rd(0, 0) !== 32'hAA || act_busy(1, 0) !== 1'b0) begin
      errors++;
      $display("FAIL sb_cleared got pend %b data %h busy_b %b want 0 aa 0", pending_a[3], act_rd(0, 0), act_busy(1, 0));
    end
  endtask

  task automatic test_collision();
    rsv_en = 1; rsv_addr = 9; wr_en = 1; wr_addr = 9; wr_data = 32'h99;
    #1;
    checks++;
    if (rsv_ok_a !== 1'b1) begin
      errors++;
      $display("FAIL coll_free_rsv_ok got %b want 1", rsv_ok_a);
    end
    @(negedge clk);
    idle();
    rd_addr = 12'd9;
    #1;
    checks++;
    if (act_rd(0, 0) !== 32'h99 || pending_a[9] !== 1'b1) begin
      errors++;
      $display("FAIL coll_free got %h pend %b want 99 1", act_rd(0, 0), pending_a[9]);
    end
    rsv_en = 1; rsv_addr = 9; wr_en = 1; wr_addr = 9; wr_data = 32'h77;
    #1;
    checks++;
    if (rsv_ok_a !== 1'b0) begin
      errors++;
      $display("FAIL coll_busy_rsv_ok got %b want 0", rsv_ok_a);
    end
    @(negedge clk);
    idle();
    rd_addr = 12'd9;
    #1;
    checks++;
    if (act_rd(0, 0) !== 32'h77 || pending_a[9] !== 1'b0) begin
      errors++;
      $display("FAIL coll_busy got %h pend %b want 77 0", act_rd(0, 0), pending_a[9]);
    end
  endtask

  task automatic test_range();
    logic [15:0] ep;
    wr_en = 1; wr_addr = 13; wr_data = 32'hCAFE0013; rd_addr = 12'd13;
    #1;
    checks++;
    if (act_rd(1, 0) !== 32'h0 || act_busy(1, 0) !== 1'b0) begin
      errors++;
      $display("FAIL range_read13 got %h busy %b want 0 0", act_rd(1, 0), act_busy(1, 0));
    end
    @(negedge clk);
    idle();
    for (int a = 0; a < 12; a++) begin
      rd_addr = 12'(a);
      #1;
      checks++;
      if (act_rd(1, 0) !== mreg[1][a]) begin
        errors++;
        $display("FAIL range_keep_r%0d got %h want %h", a, act_rd(1, 0), mreg[1][a]);
      end
    end
    ep = '0;
    for (int r = 0; r < 12; r++) ep[r] = mpend[1][r];
    checks++;
    if (act_pend(1) !== ep) begin
      errors++;
      $display("FAIL range_pending got %h want %h", act_pend(1), ep);
    end
    rd_addr = 12'd13;
    #1;
    checks++;
    if (act_rd(1, 0) !== 32'h0 || act_rd(0, 0) !== 32'hCAFE0013) begin
      errors++;
      $display("FAIL range_after got b=%h a=%h want 0 cafe0013", act_rd(1, 0), act_rd(0, 0));
    end
    @(negedge clk);
  endtask

  task automatic test_random(int cycles);
    logic [15:0] ep;
    logic [31:0] ed;
    logic        eb, eo;
    int          a;
    for (int c = 0; c < cycles; c++) begin
      randomize_inputs();
      #1;
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 3; i++) begin
          a  = int'(rd_addr[i*4 +: 4]);
          ed = '0;
          eb = 1'b0;
          if (mvalid(k, a)) begin
            if (mbyp[k] && wr_en && int'(wr_addr) == a) begin
              ed = wr_data;
            end else begin
              ed = mreg[k][a];
              eb = mpend[k][a];
            end
          end
          checks++;
          if (act_rd(k, i) !== ed || act_busy(k, i) !== eb) begin
            errors++;
            $display("FAIL rand_read k%0d p%0d a%0d got %h/%b want %h/%b", k, i, a, act_rd(k, i), act_busy(k, i), ed, eb);
          end
        end
        eo = rsv_en && mvalid(k, int'(rsv_addr)) && !mpend[k][rsv_addr];
        ep = '0;
        for (int r = 0; r < msize[k]; r++) ep[r] = mpend[k][r];
        checks++;
        if (((k == 0) ? rsv_ok_a : rsv_ok_b) !== eo || act_pend(k) !== ep) begin
          errors++;
          $display("FAIL rand_sb k%0d rsv_ok %b/%b pending %h want %b/%h", k, rsv_ok_a, rsv_ok_b, act_pend(k), eo, ep);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    test_random(20);
    randomize_inputs();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rd_data_a !== '0 || rd_data_b !== '0 || pending_a !== '0 || pending_b !== '0 || rsv_ok_a !== 0 || rsv_ok_b !== 0) begin
      errors++;
      $display("FAIL midreset_async rd %h/%h pend %h/%h rsv %b/%b want 0", rd_data_a, rd_data_b, pending_a, pending_b, rsv_ok_a, rsv_ok_b);
    end
    @(negedge clk);
    #1;
    checks++;
    if (pending_a !== '0 || pending_b !== '0 || rd_busy_a !== '0 || rd_busy_b !== '0) begin
      errors++;
      $display("FAIL midreset_hold pend %h/%h busy %b/%b want 0", pending_a, pending_b, rd_busy_a, rd_busy_b);
    end
    idle();
    rst = 1'b0;
    wr_en = 1; wr_addr = 2; wr_data = 32'h55; rsv_en = 1; rsv_addr = 4;
    @(negedge clk);
    idle();
    rd_addr = {4'd4, 4'd1, 4'd2};
    #1;
    checks++;
    if (act_rd(0, 0) !== 32'h55 || act_rd(1, 0) !== 32'h55 || act_rd(1, 1) !== 32'h0) begin
      errors++;
      $display("FAIL midreset_first_edge got %h %h %h want 55 55 0", act_rd(0, 0), act_rd(1, 0), act_rd(1, 1));
    end
    checks++;
    if (pending_a !== 16'h0010 || pending_b !== 12'h010 || act_busy(0, 2) !== 1'b1) begin
      errors++;
      $display("FAIL midreset_rsv got %h %h busy %b want 0010 010 1", pending_a, pending_b, act_busy(0, 2));
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_basic();
    test_bypass();
    test_zero();
    test_scoreboard();
    test_collision();
    test_range();
    test_random(400);
    test_reset_mid();
    test_random(200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with N combinational read ports, one write port, optional write-through bypass, an optional hardwired zero register, and a per-register scoreboard of pending-write bits. It supersedes the fixed two-read-port register file in the datapath. The issue stage uses it to reserve a destination register when a multi-cycle operation is dispatched. Writeback clears that reservation when the result lands.

## Interface
- WORD, 32: data width in bits.
- SIZE, 16: number of registers, 2..256, not required to be a power of two.
- NREAD, 2: number of read ports, 1..8.
- ZERO_REG, 1: when 1, register 0 reads as zero, ignores writes and is never pending.
- BYPASS, 1: when 1, read ports forward same-cycle write data.
- AW (derived): $clog2(SIZE), minimum 1.

Ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  WORD  write data.
- rd_addr  in  NREAD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NREAD*WORD  packed read data; port i uses bits [i*WORD +: WORD].
- rd_busy  out  NREAD  port i is addressing a register with a pending write.
- rsv_en  in  1  request to reserve rsv_addr as a destination.
- rsv_addr  in  AW  register to reserve.
- rsv_ok  out  1  reservation accepted this cycle.
- pending  out  SIZE  scoreboard vector; bit r set means register r awaits a write.

## Operation
- Reset, asynchronous: all registers go to 0 and pending goes to 0 immediately. rd_data and rd_busy follow combinationally, so rd_data = 0 and rd_busy = 0. Reset asserted mid-operation discards any in-flight reservation or write.
- Valid address: addr < SIZE and not (ZERO_REG && addr == 0).
- Write: if wr_en and wr_addr is valid, reg[wr_addr] <= wr_data and pending[wr_addr] <= 0 at the edge. An invalid wr_addr is a no-op.
- Reservation: rsv_ok = rsv_en & valid(rsv_addr) & ~pending[rsv_addr]. It is purely combinational from current state. If rsv_ok is high, pending[rsv_addr] <= 1 at the edge. A rejected request changes nothing; the requester retries.
- Simultaneous write and reservation, same address:
  - If pending was 1, the reservation is rejected. The write lands and the pending bit clears.
  - If pending was 0, the reservation is accepted and the write lands. After the edge the register holds wr_data and the pending bit is 1, because the new reservation wins.
- Simultaneous write and reservation, different addresses: both take effect independently.
- Read port i, with a = rd_addr[i]:
  - a >= SIZE, or a == 0 with ZERO_REG set: rd_data is 0 and rd_busy is 0.
  - Otherwise, if BYPASS && wr_en && wr_addr == a: rd_data = wr_data and rd_busy = 0.
  - Otherwise: rd_data = reg[a] and rd_busy = pending[a].
- Multiple read ports may address the same register; each returns identical data.
- Writing a register that is not pending is legal and does not set pending.

## Timing
- Read latency: 0 cycles, combinational from rd_addr and state.
- Write-to-read latency:
  - BYPASS = 1: visible in the same cycle.
  - BYPASS = 0: visible the cycle after the edge.
- rsv_ok is valid in the same cycle as rsv_en. The pending bit is visible the cycle after the accepting edge.
- The write-to-pending-clear latency is 1 edge. rd_busy deasserts in the write cycle when BYPASS = 1, and the next cycle when BYPASS = 0.
- No combinational path from rsv_en to rd_data or rd_busy.
- Reset release: the first edge with rst low performs normal updates.

## Test plan
- Reset value: hold rst with random inputs. Expect rd_data = 0, rd_busy = 0, pending = 0 and rsv_ok = 0 for every address; also when reset is asserted mid-burst.
- Basic write/read (SIZE = 16, NREAD = 3): write 0xDEADBEEF to r5. Read r5 on all three ports next cycle and expect 0xDEADBEEF on each. Read r6 and expect 0.
- Bypass: write 0x1234 to r7 while rd_addr[0] = 7.
  - BYPASS = 1: expect 0x1234 in the same cycle.
  - BYPASS = 0: expect the old value, then 0x1234 next cycle.
- Zero register: write 0xFFFF to r0 and expect rd_data = 0 afterwards. Reserve r0 and expect rsv_ok = 0 and pending[0] = 0.
- Scoreboard handshake: reserve r3 and expect rsv_ok = 1, then pending[3] = 1 and rd_busy = 1 when r3 is read. Re-reserve r3 and expect rsv_ok = 0. Write 0xAA to r3 and expect pending[3] = 0 and rd_data = 0xAA.
- Collisions and range:
  - Reserve and write r9 in the same cycle while pending[9] = 0. Expect reg = data and pending[9] = 1.
  - Repeat while pending[9] = 1. Expect rsv_ok = 0 and pending[9] = 0.
  - With SIZE = 12: a write to address 13 leaves all registers unchanged, and a read of address 13 returns 0.
